tcam_update_ctrl: RTL and testbench

- Upstream management stage for the single-port ternary CAM array (one write port plus one match port).
- Accepts insert/delete requests over a valid/ready handshake and tracks entry occupancy in a valid bitmap.
- For inserts it runs a coverage lookup on the CAM match port, allocates the lowest free slot, and drives the CAM write port.
- Returns a status/address response over a second valid/ready handshake.

---
 rtl/tcam_upd_pkg.sv | 37 +++
 rtl/tcam_update_ctrl_free_slot_finder.sv | 30 +++
 rtl/tcam_update_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_tcam_update_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_upd_pkg.sv
// ----------------------------------------------------------------------------
// tcam_upd_pkg
// Shared types and constants for the TCAM update controller.
//   op_e     : request operation (insert / delete)
//   status_e : response status codes
//   state_e  : controller FSM states
//   STAT_W   : width of the optional statistics counters
//   sat_inc  : saturating increment used by the statistics counters
// ----------------------------------------------------------------------------
package tcam_upd_pkg;

   localparam int STAT_W = 16;

   typedef enum logic {
      OP_INSERT = 1'b0,
      OP_DELETE = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      ST_OK        = 2'd0,
      ST_COVERED   = 2'd1,
      ST_FULL      = 2'd2,
      ST_NOT_FOUND = 2'd3
   } status_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      WRITE  = 2'd2,
      RESP   = 2'd3
   } state_e;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/tcam_update_ctrl_free_slot_finder.sv
// ----------------------------------------------------------------------------
// free_slot_finder
// Combinational priority encoder returning the lowest-index free CAM slot.
//   free_i : DEPTH-bit bitmap, 1 = slot free
//   idx_o  : lowest free index (0 when none free)
//   any_o  : at least one slot is free
// ----------------------------------------------------------------------------
module free_slot_finder #(
   parameter int DEPTH = 64
) (
   input  logic [DEPTH-1:0]         free_i,
   output logic [$clog2(DEPTH)-1:0] idx_o,
   output logic                     any_o
);

   localparam int AW = $clog2(DEPTH);

   // Scan from the top down so the last hit written is the lowest index.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int unsigned i = DEPTH; i > 0; i--) begin
         if (free_i[i-1]) begin
            idx_o = AW'(i - 1);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tcam_update_ctrl.sv
// ----------------------------------------------------------------------------
// tcam_update_ctrl
// Management stage in front of a single-port ternary CAM. Accepts insert /
// delete requests, performs a coverage lookup for inserts, allocates the
// lowest free slot, drives the CAM write port and returns a status response.
// Occupancy is tracked with a valid bitmap; CAM contents are never scrubbed,
// stale entries are hidden by the cleared bitmap.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake
//   req_op/patt/mask/addr          request fields (0=INSERT, 1=DELETE)
//   rsp_valid/rsp_ready            response handshake
//   rsp_status/rsp_addr            response fields
//   cam_wEn/wAddr/wPatt/wMask      CAM write port
//   cam_mPatt, cam_match, cam_mAddr CAM match port (match is combinational)
//   occupancy, full, empty         occupancy status
//   stat_ins/del/rej               response counters (TCAM_UPD_STATS_EN only)
//
// Build option: define TCAM_UPD_STATS_EN to add the statistics counters.
// ----------------------------------------------------------------------------
module tcam_update_ctrl
   import tcam_upd_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int WIDTH = 36
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_op,
   input  logic [WIDTH-1:0]         req_patt,
   input  logic [WIDTH-1:0]         req_mask,
   input  logic [$clog2(DEPTH)-1:0] req_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [1:0]               rsp_status,
   output logic [$clog2(DEPTH)-1:0] rsp_addr,
   output logic                     cam_wEn,
   output logic [$clog2(DEPTH)-1:0] cam_wAddr,
   output logic [WIDTH-1:0]         cam_wPatt,
   output logic [WIDTH-1:0]         cam_wMask,
   output logic [WIDTH-1:0]         cam_mPatt,
   input  logic                     cam_match,
   input  logic [$clog2(DEPTH)-1:0] cam_mAddr,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     full,
   output logic                     empty
`ifdef TCAM_UPD_STATS_EN
   ,
   output logic [STAT_W-1:0]        stat_ins,
   output logic [STAT_W-1:0]        stat_del,
   output logic [STAT_W-1:0]        stat_rej
`endif
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] OCC_ONE = {{AW{1'b0}}, 1'b1};

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   status_e            status_q, status_d;
   logic [WIDTH-1:0]   patt_q, patt_d;
   logic [WIDTH-1:0]   mask_q, mask_d;
   // Holds the delete address, then the allocated / covering / response address.
   logic [AW-1:0]      addr_q, addr_d;
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic [AW:0]        occ_q, occ_d;
   logic [AW-1:0]      free_idx;
   logic               free_any;

   free_slot_finder #(
      .DEPTH (DEPTH)
   ) u_free_slot_finder (
      .free_i (~valid_q),
      .idx_o  (free_idx),
      .any_o  (free_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= OP_INSERT;
         status_q <= ST_OK;
         patt_q   <= '0;
         mask_q   <= '0;
         addr_q   <= '0;
         valid_q  <= '0;
         occ_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         status_q <= status_d;
         patt_q   <= patt_d;
         mask_q   <= mask_d;
         addr_q   <= addr_d;
         valid_q  <= valid_d;
         occ_q    <= occ_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      status_d = status_q;
      patt_d   = patt_q;
      mask_d   = mask_q;
      addr_d   = addr_q;
      valid_d  = valid_q;
      occ_d    = occ_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d   = op_e'(req_op);
               patt_d = req_patt;
               mask_d = req_mask;
               addr_d = req_addr;
               if (op_e'(req_op) == OP_INSERT) begin
                  state_d = LOOKUP;
               end else if (valid_q[req_addr]) begin
                  state_d = WRITE;
               end else begin
                  status_d = ST_NOT_FOUND;
                  state_d  = RESP;
               end
            end
         end
         LOOKUP: begin
            // A match on an invalid (stale) slot does not count as coverage.
            if (cam_match && valid_q[cam_mAddr]) begin
               status_d = ST_COVERED;
               addr_d   = cam_mAddr;
               state_d  = RESP;
            end else if ((occ_q == DEPTH_C) || !free_any) begin
               status_d = ST_FULL;
               addr_d   = '0;
               state_d  = RESP;
            end else begin
               addr_d  = free_idx;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (op_q == OP_INSERT) begin
               valid_d[addr_q] = 1'b1;
               occ_d           = occ_q + OCC_ONE;
            end else begin
               valid_d[addr_q] = 1'b0;
               occ_d           = occ_q - OCC_ONE;
            end
            status_d = ST_OK;
            state_d  = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready  = (state_q == IDLE);
   assign rsp_valid  = (state_q == RESP);
   assign rsp_status = status_q;
   assign rsp_addr   = addr_q;

   // Write port is decoded straight from the state register, so an async
   // reset during WRITE drops cam_wEn immediately.
   assign cam_wEn   = (state_q == WRITE);
   assign cam_wAddr = cam_wEn ? addr_q : '0;
   assign cam_wPatt = (cam_wEn && op_q == OP_INSERT) ? patt_q : '0;
   assign cam_wMask = (cam_wEn && op_q == OP_INSERT) ? mask_q : '0;
   assign cam_mPatt = patt_q;

   assign occupancy = occ_q;
   assign full      = (occ_q == DEPTH_C);
   assign empty     = (occ_q == '0);

`ifdef TCAM_UPD_STATS_EN
   logic [STAT_W-1:0] stat_ins_q, stat_del_q, stat_rej_q;
   logic              rsp_hs;

   assign rsp_hs = rsp_valid && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ins_q <= '0;
         stat_del_q <= '0;
         stat_rej_q <= '0;
      end else if (rsp_hs) begin
         if (status_q == ST_OK) begin
            if (op_q == OP_INSERT) begin
               stat_ins_q <= sat_inc(stat_ins_q);
            end else begin
               stat_del_q <= sat_inc(stat_del_q);
            end
         end else begin
            stat_rej_q <= sat_inc(stat_rej_q);
         end
      end
   end

   assign stat_ins = stat_ins_q;
   assign stat_del = stat_del_q;
   assign stat_rej = stat_rej_q;
`endif

endmodule

// File: tb/tb_tcam_update_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tcam_update_ctrl
// Bench for tcam_update_ctrl (DEPTH=8, WIDTH=8) with a behavioural ternary
// CAM array attached to the write/match ports. Expected responses come from
// an entry-table reference model kept in the bench.
// ----------------------------------------------------------------------------
module tb_tcam_update_ctrl;
   import tcam_upd_pkg::*;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_op = 1'b0;
   logic [7:0]       req_patt = '0;
   logic [7:0]       req_mask = '0;
   logic [2:0]       req_addr = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [1:0]       rsp_status;
   logic [2:0]       rsp_addr;
   logic             cam_wEn;
   logic [2:0]       cam_wAddr;
   logic [7:0]       cam_wPatt;
   logic [7:0]       cam_wMask;
   logic [7:0]       cam_mPatt;
   logic             cam_match;
   logic [2:0]       cam_mAddr;
   logic [3:0]       occupancy;
   logic             full;
   logic             empty;
`ifdef TCAM_UPD_STATS_EN
   logic [15:0]      stat_ins, stat_del, stat_rej;
`endif

   int checks = 0;
   int failures = 0;
   int exp_ins = 0, exp_del = 0, exp_rej = 0;

   always #5 clk = ~clk;

   tcam_update_ctrl #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_patt   (req_patt),
      .req_mask   (req_mask),
      .req_addr   (req_addr),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_status (rsp_status),
      .rsp_addr   (rsp_addr),
      .cam_wEn    (cam_wEn),
      .cam_wAddr  (cam_wAddr),
      .cam_wPatt  (cam_wPatt),
      .cam_wMask  (cam_wMask),
      .cam_mPatt  (cam_mPatt),
      .cam_match  (cam_match),
      .cam_mAddr  (cam_mAddr),
      .occupancy  (occupancy),
      .full       (full),
      .empty      (empty)
`ifdef TCAM_UPD_STATS_EN
      ,
      .stat_ins   (stat_ins),
      .stat_del   (stat_del),
      .stat_rej   (stat_rej)
`endif
   );

   // CAM array: stale power-up contents, never scrubbed by reset.
   logic [7:0] cam_p [8] = '{8'hA5, 8'h00, 8'h3C, 8'h07, 8'h10, 8'h20, 8'hFF, 8'h55};
   logic [7:0] cam_m [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

   always @(posedge clk) begin
      if (cam_wEn) begin
         cam_p[cam_wAddr] <= cam_wPatt;
         cam_m[cam_wAddr] <= cam_wMask;
      end
   end

   always_comb begin
      cam_match = 1'b0;
      cam_mAddr = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (((cam_mPatt ^ cam_p[i]) & cam_m[i]) == 8'h00) begin
            cam_match = 1'b1;
            cam_mAddr = 3'(i);
         end
      end
   end

   // Reference model: what the CAM should hold and which entries are live.
   logic [7:0] m_p [8] = '{8'hA5, 8'h00, 8'h3C, 8'h07, 8'h10, 8'h20, 8'hFF, 8'h55};
   logic [7:0] m_m [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
   bit         m_v [8];

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(m_v[i]);
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      exp_ins = 0;
      exp_del = 0;
      exp_rej = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_status();
      int n;
      n = m_count();
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_req_ready", req_ready, 1);
      chk("idle_wen", cam_wEn, 0);
      chk("occupancy", occupancy, n);
      chk("full", full, (n == DEPTH) ? 1 : 0);
      chk("empty", empty, (n == 0) ? 1 : 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      chk("rst_wen", cam_wEn, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_status", rsp_status, 0);
      chk("rst_rsp_addr", rsp_addr, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle_status();
   endtask

   // One complete request/response transaction checked against the model.
   task automatic run_req(input logic op, input logic [7:0] patt, input logic [7:0] mask,
                          input logic [2:0] a, input int hold, input bit do_reset);
      int         e_st, e_addr, e_lat, first, slot, lat, wcnt, wcyc;
      bit         e_w, got;
      logic [7:0] e_wp, e_wm, wp, wm;
      logic [2:0] wa;
      e_w = 0; first = -1; slot = -1; e_st = 0; e_addr = 0; e_lat = 0;
      if (op == 1'b1) begin
         e_addr = a;
         if (m_v[a]) begin e_st = 0; e_lat = 2; e_w = 1; end
         else begin e_st = 3; e_lat = 1; end
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (first < 0 && ((patt ^ m_p[i]) & m_m[i]) == 8'h00) first = i;
         for (int i = DEPTH - 1; i >= 0; i--)
            if (!m_v[i]) slot = i;
         if (first >= 0 && m_v[first]) begin e_st = 1; e_addr = first; e_lat = 2; end
         else if (slot < 0) begin e_st = 2; e_addr = 0; e_lat = 2; end
         else begin e_st = 0; e_addr = slot; e_lat = 3; e_w = 1; end
      end
      e_wp = op ? 8'h00 : patt;
      e_wm = op ? 8'h00 : mask;

      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_patt = patt; req_mask = mask; req_addr = a;
      rsp_ready = (hold == 0);
      chk("req_ready_idle", req_ready, 1);
      @(posedge clk);
      wcnt = 0; wcyc = 0; got = 0; lat = 0; wa = '0; wp = '0; wm = '0;
      for (int c = 1; c <= 8 && !got; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (cam_wEn === 1'b1) begin
            wcnt++; wcyc = c; wa = cam_wAddr; wp = cam_wPatt; wm = cam_wMask;
            if (do_reset) begin
               #1 rst_n = 1'b0;
               #1;
               chk("rst_mid_wen_drop", cam_wEn, 0);
               chk("rst_mid_occ", occupancy, 0);
               chk("rst_mid_empty", empty, 1);
               chk("rst_mid_rsp_valid", rsp_valid, 0);
               model_reset();
               @(negedge clk);
               rst_n = 1'b1;
               rsp_ready = 1'b0;
               @(negedge clk);
               chk_idle_status();
               return;
            end
         end
         if (rsp_valid === 1'b1) begin got = 1; lat = c; end
      end
      chk("rsp_timeout", got, 1);
      chk("latency", lat, e_lat);
      chk("wen_count", wcnt, e_w ? 1 : 0);
      if (e_w) begin
         chk("wen_cycle", wcyc, op ? 1 : 2);
         chk("wen_addr", wa, e_addr);
         chk("wen_patt", wp, e_wp);
         chk("wen_mask", wm, e_wm);
      end
      chk("rsp_status", rsp_status, e_st);
      chk("rsp_addr", rsp_addr, e_addr);
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_op = 1'b0;
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_status", rsp_status, e_st);
            chk("hold_addr", rsp_addr, e_addr);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_wen", cam_wEn, 0);
         end
         req_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      if (e_w) begin
         m_p[e_addr] = e_wp;
         m_m[e_addr] = e_wm;
         m_v[e_addr] = (op == 1'b0);
      end
      if (e_st == 0) begin
         if (op == 1'b0) exp_ins++;
         else exp_del++;
      end else begin
         exp_rej++;
      end
      chk_idle_status();
   endtask

   initial begin
      logic [7:0] masks [4];
      logic       r_op;
      int         r_hold;
      masks[0] = 8'hFF; masks[1] = 8'hF0; masks[2] = 8'h0F; masks[3] = 8'hFF;

      apply_reset();

      run_req(1'b0, 8'hA5, 8'hFF, 3'd0, 0, 1'b0);
      run_req(1'b0, 8'hA5, 8'hFF, 3'd0, 0, 1'b0);

      apply_reset();
      for (int i = 0; i < DEPTH; i++)
         run_req(1'b0, 8'(i), 8'hFF, 3'd0, 0, 1'b0);
      run_req(1'b0, 8'h10, 8'hFF, 3'd0, 0, 1'b0);
      run_req(1'b1, 8'h00, 8'h00, 3'd3, 0, 1'b0);
      run_req(1'b1, 8'h00, 8'h00, 3'd3, 0, 1'b0);
      run_req(1'b0, 8'h20, 8'hFF, 3'd0, 0, 1'b0);

      run_req(1'b1, 8'h00, 8'h00, 3'd5, 5, 1'b0);
      run_req(1'b0, 8'h30, 8'hFF, 3'd0, 0, 1'b1);

      for (int n = 0; n < 160; n++) begin
         r_op   = ($urandom_range(0, 2) == 0);
         r_hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_req(r_op, 8'($urandom_range(0, 15)), masks[$urandom_range(0, 3)],
                 3'($urandom_range(0, 7)), r_hold, 1'b0);
      end

`ifdef TCAM_UPD_STATS_EN
      chk("stat_ins", stat_ins, exp_ins);
      chk("stat_del", stat_del, exp_del);
      chk("stat_rej", stat_rej, exp_rej);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
